// File: rtl/sync_fifo_if.sv
// Handshake bundle between a FIFO and the logic that feeds and drains it.
// The FIFO side uses the slave modport; producer/consumer logic uses master.
`ifndef FE_DATA_W
`define FE_DATA_W 32
`endif

interface sync_fifo_if #(
    parameter int DATA_W = `FE_DATA_W
);
    logic              w_en;
    logic [DATA_W-1:0] data_in;
    logic              r_en;
    logic [DATA_W-1:0] data_out;
    logic              empty;
    logic              full;

    modport master (
        output w_en, data_in, r_en,
        input  data_out, empty, full
    );

    modport slave (
        input  w_en, data_in, r_en,
        output data_out, empty, full
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data: a word is on data_out one edge after its read.
// Flags come straight from the pointers; writes while full are dropped, reads while empty ignored.
`ifndef FE_DATA_W
`define FE_DATA_W 32
`endif

module sync_fifo #(
    parameter int DATA_W = `FE_DATA_W,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input logic       clk,
    input logic       rst_n,
    sync_fifo_if.slave bus
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [DATA_W-1:0] data_q;
    logic              empty_w;
    logic              full_w;
    logic              wr_acc;
    logic              rd_acc;

    // Extra pointer MSB distinguishes a full buffer from an empty one.
    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    assign wr_acc = bus.w_en && !full_w;
    assign rd_acc = bus.r_en && !empty_w;

    assign bus.empty    = empty_w;
    assign bus.full     = full_w;
    assign bus.data_out = data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            data_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                data_q <= mem[rd_ptr[ADDR_W-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is never cleared; reset only blocks the write so nothing lands during it.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr[ADDR_W-1:0]] <= bus.data_in;
        end
    end
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a driver issues vectors and queues expected read words,
// a monitor pops and compares data_out after every edge.
module tb_sync_fifo;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] exp_q[$];
    logic        exp_take = 1'b0;
    logic        exp_rst  = 1'b1;
    logic        take_l   = 1'b0;
    logic        rst_l    = 1'b0;
    logic [31:0] exp_dout = 32'h0;

    sync_fifo_if #(.DATA_W(32)) bus ();

    sync_fifo #(.DATA_W(32), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Monitor: latch what the driver intended at the edge, compare at the next negedge.
    always @(posedge clk) begin
        take_l <= exp_take;
        rst_l  <= exp_rst;
    end

    always @(negedge clk) begin
        if (rst_l) begin
            exp_dout = 32'h0;
        end else if (take_l) begin
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard: read issued with no expected word queued");
            end else begin
                exp_dout = exp_q.pop_front();
            end
        end
        checks++;
        if (bus.data_out !== exp_dout) begin
            failures++;
            $display("FAIL data_out @%0t: got %h expected %h", $time, bus.data_out, exp_dout);
        end
    end

    task automatic cyc(input logic rst, input logic w, input logic r, input logic [31:0] d,
                       input logic rd_ok, input logic [31:0] ew, input int occ, input string nm);
        @(negedge clk);
        rst_n       = rst;
        bus.w_en    = w;
        bus.r_en    = r;
        bus.data_in = d;
        if (rd_ok) exp_q.push_back(ew);
        exp_take = rd_ok;
        exp_rst  = !rst;
        @(posedge clk);
        #1;
        checks++;
        if (bus.empty !== (occ == 0) || bus.full !== (occ == 8)) begin
            failures++;
            $display("FAIL %s flags: empty=%b full=%b expected empty=%b full=%b",
                     nm, bus.empty, bus.full, (occ == 0), (occ == 8));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.w_en    = 1'b0;
        bus.r_en    = 1'b0;
        bus.data_in = 32'h0;

        // Reset with both requests active
        cyc(0, 1, 1, 32'hEE, 0, 0, 0, "reset0");
        cyc(0, 1, 1, 32'hEF, 0, 0, 0, "reset1");

        // Ordering
        cyc(1, 1, 0, 32'hA1, 0, 0, 1, "wr_a1");
        cyc(1, 1, 0, 32'hB2, 0, 0, 2, "wr_b2");
        cyc(1, 1, 0, 32'hC3, 0, 0, 3, "wr_c3");
        cyc(1, 0, 1, 32'h0, 1, 32'hA1, 2, "rd_a1");
        cyc(1, 0, 1, 32'h0, 1, 32'hB2, 1, "rd_b2");
        cyc(1, 0, 1, 32'h0, 1, 32'hC3, 0, "rd_c3");

        // Underflow: data_out must hold 0xC3
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 32'h0, 0, 0, 0, "underflow");
        cyc(1, 1, 0, 32'h5A, 0, 0, 1, "wr_5a");
        cyc(1, 0, 1, 32'h0, 1, 32'h5A, 0, "rd_5a");

        // Fill to full, overflow write dropped, drain
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 32'h10 + i, 0, 0, i + 1, "fill");
        cyc(1, 1, 0, 32'hFF, 0, 0, 8, "overflow");
        for (int i = 0; i < 8; i++) cyc(1, 0, 1, 32'h0, 1, 32'h10 + i, 7 - i, "drain");

        // Simultaneous traffic at occupancy 4, crossing pointer wrap
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 32'h20 + i, 0, 0, i + 1, "prefill");
        for (int i = 0; i < 10; i++) cyc(1, 1, 1, 32'h24 + i, 1, 32'h20 + i, 4, "rw_steady");
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 32'h2E + i, 0, 0, 5 + i, "topup");
        // Both at full: read accepted, write dropped
        cyc(1, 1, 1, 32'hEE, 1, 32'h2A, 7, "rw_full");
        for (int i = 0; i < 7; i++) cyc(1, 0, 1, 32'h0, 1, 32'h2B + i, 6 - i, "drain2");
        // Both at empty: write accepted, read ignored, data_out keeps 0x31
        cyc(1, 1, 1, 32'h77, 0, 0, 1, "rw_empty");
        cyc(1, 0, 1, 32'h0, 1, 32'h77, 0, "rd_77");

        // Mid-run reset discards queued words
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 32'h60 + i, 0, 0, i + 1, "prefill5");
        cyc(0, 0, 0, 32'h0, 0, 0, 0, "midreset");
        cyc(1, 1, 0, 32'h55, 0, 0, 1, "wr_55");
        cyc(1, 0, 1, 32'h0, 1, 32'h55, 0, "rd_55");
        cyc(1, 0, 0, 32'h0, 0, 0, 0, "idle");

        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d words left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, first-in first-out buffer holding data words between a producer and a consumer inside the same clock domain. It decouples a memory-facing load/store engine from a compute accelerator: one instance queues loaded words toward the accelerator, another queues accelerator results toward memory. Read data is registered. Status flags are derived directly from the internal pointers.

## Interface
Parameters:
- DATA_W, default `FE_DATA_W` (32): word width.
- DEPTH, default 8: number of entries. Must be a power of two, ≥2.
- ADDR_W, default $clog2(DEPTH): pointer index width. Derived; do not override.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- w_en  in  1  write request.
- data_in  in  DATA_W  write data, captured when a write is accepted.
- r_en  in  1  read request.
- data_out  out  DATA_W  registered read data.
- empty  out  1  high when the FIFO holds 0 entries.
- full  out  1  high when the FIFO holds DEPTH entries.

## Operation
- Storage: DEPTH×DATA_W array. Write pointer wr_ptr and read pointer rd_ptr are each ADDR_W+1 bits wide; the extra MSB is the wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]).
- Write accepted when w_en && !full, using flags sampled before the edge:
  - mem[wr_ptr[ADDR_W-1:0]] <= data_in
  - wr_ptr <= wr_ptr + 1, modulo 2^(ADDR_W+1).
- Write with full=1 is dropped silently: no pointer or storage change.
- Read accepted when r_en && !empty:
  - data_out <= mem[rd_ptr[ADDR_W-1:0]]
  - rd_ptr <= rd_ptr + 1
- Read with empty=1 is ignored; data_out holds its previous value.
- When no read is accepted, data_out holds its value. No fall-through.
- Simultaneous w_en and r_en:
  - Neither full nor empty: both are accepted; occupancy is unchanged.
  - full=1: the read is accepted and the write is dropped.
  - empty=1: the write is accepted and the read is ignored. The new word is not visible on data_out that cycle.
- Pointer wrap-around is natural binary overflow; no special case.
- Reset (rst_n=0 at a clock edge): wr_ptr=0, rd_ptr=0, data_out=0. Hence empty=1 and full=0.
  - Storage contents are not cleared.
  - Reset has priority over any simultaneous w_en/r_en.
  - Reset mid-operation discards all queued words.

## Timing
- Write-to-empty latency: a word written at edge N clears empty right after edge N (combinational from the pointers).
- Read latency: r_en high before edge N gives the word on data_out right after edge N. The consumer samples it from cycle N+1 onward.
- The word stays stable until the next accepted read.
- full asserts right after the edge that accepts the DEPTH-th outstanding write.
- full deasserts right after the edge of an accepted read.
- No output depends combinationally on w_en or r_en.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with w_en=r_en=1 → empty=1, full=0, data_out=0; nothing stored.
- Order: write 0xA1, 0xB2, 0xC3 on consecutive cycles, then read 3 times → data_out shows 0xA1, 0xB2, 0xC3, each one cycle after its r_en edge. empty=1 after the third read.
- Full: write 8 words (DEPTH=8) 0x10..0x17 → full=1 after the 8th write. A 9th write of 0xFF is dropped. Reading 8 times returns 0x10..0x17; 0xFF never appears.
- Empty underflow: with empty=1, assert r_en for 3 cycles → data_out keeps its last value; the pointers do not move; a subsequent write/read returns the correct word.
- Simultaneous: with 4 entries held, assert w_en+r_en for 10 cycles using an incrementing pattern → occupancy stays 4 and order is preserved across pointer wrap. With full=1, assert both → one word is read, the write is dropped, and full deasserts.
- Mid-run reset: with 5 entries held, pulse rst_n=0 for one cycle → empty=1. The next write of 0x55 followed by a read returns 0x55.
